// File: rtl/sprite_frame_sequencer.sv
// Frame-synchronised sprite position register file: host writes queue in a FIFO and commit at vblank start.
// Optional SPRITE_SEQ_DROP_STATS_EN adds a saturating dropped-write counter (drop_count).
module sprite_frame_sequencer #(
    parameter int NUM_REGS    = 12,
    parameter int FIFO_DEPTH  = 8,
    parameter int VACTIVE     = 480,
    parameter int ANIM_FRAMES = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  chipselect,
    input  logic                  write,
    input  logic [8:0]            address,
    input  logic [31:0]           writedata,
    input  logic [9:0]            vcount,
    output logic [8*NUM_REGS-1:0] pos_regs,
    output logic [1:0]            walk_state,
    output logic [15:0]           frame_count,
    output logic                  commit_done,
    output logic                  overflow
`ifdef SPRITE_SEQ_DROP_STATS_EN
    ,
    output logic [7:0]            drop_count
`endif
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int ANIM_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam logic [8:0] NUM_REGS_A = 9'(NUM_REGS);
    localparam logic [9:0] VBLANK_LINE = 10'(VACTIVE);

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    function automatic logic [7:0] reset_value(input int idx);
        case (idx)
            0:       reset_value = 8'd100;
            1:       reset_value = 8'd100;
            2:       reset_value = 8'd200;
            3:       reset_value = 8'd150;
            4:       reset_value = 8'd44;
            5:       reset_value = 8'd200;
            6:       reset_value = 8'd244;
            7:       reset_value = 8'd100;
            8:       reset_value = 8'd100;
            9:       reset_value = 8'd4;
            10:      reset_value = 8'd160;
            11:      reset_value = 8'd192;
            default: reset_value = 8'd0;
        endcase
    endfunction

    logic [9:0]       vcount_q;
    logic             vblank_start;
    logic [11:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             host_wr;
    logic             reg_wr;
    logic             clear_wr;
    logic             push;
    logic             drop;
    logic             pop;
    logic [3:0]       pop_addr;
    logic [7:0]       pop_data;
    logic [CNT_W-1:0] pending_q;
    logic [CNT_W-1:0] pending_d;
    state_t           state_q;
    state_t           state_d;
    logic [7:0]       regs [NUM_REGS];
    logic [ANIM_W-1:0] anim_cnt;
    logic             unused_wdata;

    assign unused_wdata = ^writedata[31:8];

    assign vblank_start = (vcount == VBLANK_LINE) && (vcount_q != VBLANK_LINE);
    assign host_wr      = chipselect && write;
    assign reg_wr       = host_wr && (address < NUM_REGS_A);
    assign clear_wr     = host_wr && (address == 9'h1FF) && writedata[0];
    // Full is judged on the pre-pop occupancy, so a same-cycle pop never rescues a write.
    assign fifo_full    = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign push         = reg_wr && !fifo_full;
    assign drop         = reg_wr && fifo_full;
    assign {pop_addr, pop_data} = fifo_mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (vblank_start && (fifo_count != '0))
                    state_d = (fifo_count == CNT_W'(1)) ? DONE : DRAIN;
            end
            DRAIN: begin
                if (pending_q == CNT_W'(1))
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The first snapshot entry pops in the vblank cycle itself so entry k lands on edge k+1.
    always_comb begin
        pop       = 1'b0;
        pending_d = pending_q;
        case (state_q)
            IDLE: begin
                if (vblank_start && (fifo_count != '0)) begin
                    pop       = 1'b1;
                    pending_d = fifo_count - CNT_W'(1);
                end
            end
            DRAIN: begin
                pop       = 1'b1;
                pending_d = pending_q - CNT_W'(1);
            end
            default: begin
                pop       = 1'b0;
                pending_d = pending_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {address[3:0], writedata[7:0]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= reset_value(i);
        end else if (pop) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (pop_addr == 4'(i))
                    regs[i] <= pop_data;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign pos_regs[8*g +: 8] = regs[g];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vcount_q    <= '0;
            frame_count <= '0;
            anim_cnt    <= '0;
            walk_state  <= 2'd0;
        end else begin
            vcount_q <= vcount;
            if (vblank_start) begin
                frame_count <= frame_count + 16'd1;
                if (anim_cnt == ANIM_W'(ANIM_FRAMES - 1)) begin
                    anim_cnt   <= '0;
                    walk_state <= (walk_state == 2'd2) ? 2'd0 : walk_state + 2'd1;
                end else begin
                    anim_cnt <= anim_cnt + ANIM_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            commit_done <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            commit_done <= (state_q == DONE);
            if (drop)
                overflow <= 1'b1;
            else if (clear_wr)
                overflow <= 1'b0;
        end
    end

`ifdef SPRITE_SEQ_DROP_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            drop_count <= '0;
        else if (drop) begin
            if (drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end else if (clear_wr)
            drop_count <= '0;
    end
`endif

endmodule

// File: doc/sprite_frame_sequencer.md
Name: sprite_frame_sequencer

Overview:
Frame-synchronised configuration controller for the sprite/score drawing datapath. Host register writes are buffered in a small FIFO rather than applied straight to live position registers. The buffered writes are committed only at the start of vertical blank, so sprite positions never tear mid-frame. The block also generates the frame-based walk-animation state that selects the dino leg sprite, replacing the free-running clock divider.

Parameters:
NUM_REGS, 12, number of 8-bit position registers (dino x/y, jump x/y, duck x/y, s_cac x/y, godzilla x/y, score x/y at addresses 0..11)
FIFO_DEPTH, 8, pending-write buffer entries (power of 2)
VACTIVE, 480, first non-visible line; vblank starts when vcount reaches this value
ANIM_FRAMES, 6, frames per walk-animation step (>=1)

Ports:
clk  in  1  system clock (50 MHz)
reset_n  in  1  asynchronous, active-low reset
chipselect  in  1  host bus select
write  in  1  host write strobe
address  in  9  host register address
writedata  in  32  host write data; only [7:0] used for position registers
vcount  in  10  current line from the VGA counters
pos_regs  out  8*NUM_REGS  live register file, flat; register i at bits [8i+7:8i]
walk_state  out  2  dino leg sprite select: 0 neutral, 1 left, 2 right
frame_count  out  16  vblanks seen since reset, wraps at 65535->0
commit_done  out  1  one-cycle pulse when a vblank commit finishes
overflow  out  1  sticky: a write was dropped because the FIFO was full

Behaviour:
- Reset (async, reset_n low) values:
  - pos_regs = {100,100,200,150,44,200,244,100,100,4,160,192} for addresses 0..11 (8-bit values).
  - FIFO empty; walk_state=0; frame_count=0; commit_done=0; overflow=0; FSM in IDLE.
- Write accept, each cycle with chipselect && write:
  - address < NUM_REGS and FIFO not full: push {address[3:0], writedata[7:0]}.
  - address < NUM_REGS and FIFO full: drop the write; set overflow.
  - address == 9'h1FF and writedata[0]=1: clear overflow; nothing is pushed.
  - Any other address: ignored.
- vblank_start: single-cycle internal pulse, asserted when registered vcount_q != VACTIVE and vcount == VACTIVE.
- On vblank_start:
  - frame_count increments.
  - Animation frame counter increments. When it reaches ANIM_FRAMES-1 it wraps to 0 and walk_state advances 0->1->2->0. walk_state never takes value 3.
- FSM states:
  - IDLE: on vblank_start, snapshot pending = FIFO occupancy. pending>0 -> DRAIN. pending==0 -> stay IDLE; no commit_done.
  - DRAIN: pop one entry per cycle and write its data to pos_regs[addr]; decrement pending. After the last snapshotted entry is written -> DONE.
  - DONE: commit_done=1 for exactly this cycle -> IDLE.
- Timing and ordering:
  - Entry k (0-based) of the snapshot is visible on pos_regs at the k+1th rising edge after vblank_start.
  - Commit order equals write order; a duplicate address in one frame resolves as last write wins.
- Writes arriving during DRAIN/DONE:
  - They are pushed normally; a simultaneous push and pop is legal.
  - They are excluded from the current snapshot and commit at the next vblank.
  - Full is evaluated before the same-cycle pop, so a write in a cycle where the FIFO is full is dropped even if a pop occurs that cycle.
- A vblank_start arriving while not IDLE (impossible when FIFO_DEPTH+2 < line length) still updates the frame and animation counters but does not restart the snapshot.
- Reset asserted mid-DRAIN: everything returns to reset values immediately; uncommitted entries are lost.
- All outputs are registered; no combinational path from host inputs to outputs.

Optional Feature:
SPRITE_SEQ_DROP_STATS_EN:
- Defined: adds output drop_count [7:0]. It increments on each dropped write, saturates at 255, resets to 0, and clears together with overflow on the 9'h1FF clear write.
- Undefined: port and counter are absent; overflow behaviour is unchanged.

Test Plan:
- Post-reset: reset_n low then high, no writes -> pos_regs reg0=100, reg9=4, reg11=192; walk_state=0; overflow=0.
- Write addr0=55, addr1=77 at line 100 -> pos_regs unchanged until vcount hits 480; reg0=55 one cycle after vblank_start, reg1=77 the cycle after; commit_done pulses in the following cycle.
- Write addr3=10 then addr3=20 in one frame -> after commit reg3=20; exactly 2 drain cycles.
- 9 writes within one frame -> first 8 commit at vblank, 9th dropped, overflow=1. Then write 9'h1FF with data 1 -> overflow=0 (and drop_count 1->0 when stats enabled).
- Run 18 frames with ANIM_FRAMES=6 -> walk_state steps 0,1,2,0 at frames 6,12,18; frame_count=18.
- Assert reset_n low during DRAIN with 5 pending -> pos_regs return to reset values, FIFO empty; the next vblank produces no commit_done.
